// File: rtl/ecc_pkg.sv
// Shared SECDED definitions for the ECC encoder/decoder family:
// check-bit width, data-index <-> codeword-position mapping and status codes.
package ecc_pkg;

    typedef enum logic [1:0] {
        ST_NONE   = 2'b00,
        ST_CORR   = 2'b01,
        ST_ECC    = 2'b10,
        ST_UNCORR = 2'b11
    } ecc_sts_e;

    // Hamming bits P (smallest P with 2^P >= data_width+P+1) plus overall parity.
    function automatic int unsigned ecc_width(input int unsigned data_width);
        int unsigned p;
        p = 0;
        while ((32'd1 << p) < (data_width + p + 32'd1)) p++;
        return p + 32'd1;
    endfunction

    // Codeword position (1-based) holding data[idx]; powers of two are skipped.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned pos;
        pos = 32'd3;
        for (int unsigned k = 0; k < idx; k++) begin
            pos++;
            if ((pos & (pos - 32'd1)) == 32'd0) pos++;
        end
        return pos;
    endfunction

    // Inverse of data_pos for a non-power-of-two position.
    function automatic int unsigned pos_to_idx(input int unsigned pos);
        int unsigned lg;
        lg = 0;
        while ((32'd2 << lg) <= pos) lg++;
        return pos - lg - 32'd2;
    endfunction

endpackage

// File: rtl/ecc_syn_calc.sv
// Recomputes the Hamming check bits and the data parity of a word.
// Combinational; shared by the decoder and the parametrised encoder.
module ecc_syn_calc
    import ecc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    localparam int unsigned HAM_WIDTH  = ecc_width(DATA_WIDTH) - 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic [HAM_WIDTH-1:0]  ham_c,
    output logic                  data_par_c
);

    logic [HAM_WIDTH-1:0] contrib [DATA_WIDTH];

    // Each set data bit contributes its codeword position to the check bits.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pos
        localparam int unsigned POS = data_pos(i);
        assign contrib[i] = data[i] ? HAM_WIDTH'(POS) : '0;
    end

    always_comb begin
        ham_c = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) ham_c ^= contrib[i];
    end

    assign data_par_c = ^data;

endmodule

// File: rtl/ecc_secded_dec_stream.sv
// Two-stage pipelined SECDED decoder with valid/ready flow control,
// single-bit correction, error classification and saturating error counters.
module ecc_secded_dec_stream
    import ecc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 64,
    parameter  int unsigned CNT_WIDTH  = 16,
    localparam int unsigned ECC_WIDTH  = ecc_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ECC_WIDTH-1:0]  in_ecc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_err_sts,
    output logic [ECC_WIDTH-2:0]  out_syndrome,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  cnt_corr,
    output logic [CNT_WIDTH-1:0]  cnt_uncorr,
    output logic                  err_irq
);

    localparam int unsigned P = ECC_WIDTH - 1;
    localparam logic [P-1:0] LAST_POS = P'(DATA_WIDTH + P);

    logic [P-1:0]          ham_c;
    logic                  data_par_c;
    logic [P-1:0]          syn_c;
    logic                  mis_c;
    logic                  advance_c;
    logic                  out_hs_c;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [P-1:0]          s1_syn;
    logic                  s1_mis;

    ecc_sts_e              sts_c;
    logic                  pow2_c;
    logic [DATA_WIDTH-1:0] flip_c;
    logic [DATA_WIDTH-1:0] fix_data_c;

    ecc_syn_calc #(.DATA_WIDTH(DATA_WIDTH)) u_syn (
        .data       (in_data),
        .ham_c      (ham_c),
        .data_par_c (data_par_c)
    );

    assign syn_c = in_ecc[P-1:0] ^ ham_c;
    assign mis_c = in_ecc[P] ^ data_par_c ^ (^in_ecc[P-1:0]);

    assign advance_c = !out_valid || out_ready;
    assign in_ready  = advance_c;
    assign out_hs_c  = out_valid && out_ready;

    // S=0 also passes the power-of-two test, which folds the parity-bit case in.
    always_comb begin
        sts_c  = ST_UNCORR;
        pow2_c = ((s1_syn & (s1_syn - P'(1))) == '0);
        if ((s1_syn == '0) && !s1_mis)         sts_c = ST_NONE;
        else if (s1_mis && pow2_c)             sts_c = ST_ECC;
        else if (s1_mis && (s1_syn <= LAST_POS)) sts_c = ST_CORR;
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_fix
        localparam logic [P-1:0] POS = P'(data_pos(i));
        assign flip_c[i] = (s1_syn == POS);
    end

    assign fix_data_c = (sts_c == ST_CORR) ? (s1_data ^ flip_c) : s1_data;

    // Whole pipeline moves together; output payload only updates on a valid word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_syn       <= '0;
            s1_mis       <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_err_sts  <= ST_NONE;
            out_syndrome <= '0;
        end else if (advance_c) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_syn  <= syn_c;
                s1_mis  <= mis_c;
            end
            if (s1_valid) begin
                out_data     <= fix_data_c;
                out_err_sts  <= sts_c;
                out_syndrome <= s1_syn;
            end
        end
    end

    // Statistics counted on the output handshake; clear beats increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
            err_irq    <= 1'b0;
        end else begin
            err_irq <= out_hs_c && (out_err_sts == ST_UNCORR);
            if (cnt_clr) begin
                cnt_corr   <= '0;
                cnt_uncorr <= '0;
            end else if (out_hs_c) begin
                if (((out_err_sts == ST_CORR) || (out_err_sts == ST_ECC)) && (cnt_corr != '1))
                    cnt_corr <= cnt_corr + CNT_WIDTH'(1);
                if ((out_err_sts == ST_UNCORR) && (cnt_uncorr != '1))
                    cnt_uncorr <= cnt_uncorr + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ecc_secded_dec_stream.sv
// Bench for ecc_secded_dec_stream: 64-bit instance (directed, random stream,
// clear, reset) and a 32-bit / 2-bit-counter instance (narrow width, saturation).
module tb_ecc_secded_dec_stream;

    localparam int unsigned DW = 64, CW = 16, EW = 8;
    localparam int unsigned DWN = 32, CWN = 2, EWN = 7;
    localparam int LIMIT = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          in_valid, in_ready, out_valid, out_ready, cnt_clr, err_irq;
    logic [DW-1:0] in_data, out_data;
    logic [EW-1:0] in_ecc;
    logic [1:0]    out_err_sts;
    logic [EW-2:0] out_syndrome;
    logic [CW-1:0] cnt_corr, cnt_uncorr;

    logic           n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_cnt_clr, n_err_irq;
    logic [DWN-1:0] n_in_data, n_out_data;
    logic [EWN-1:0] n_in_ecc;
    logic [1:0]     n_out_err_sts;
    logic [EWN-2:0] n_out_syndrome;
    logic [CWN-1:0] n_cnt_corr, n_cnt_uncorr;

    ecc_secded_dec_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ecc(in_ecc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err_sts(out_err_sts), .out_syndrome(out_syndrome),
        .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr), .err_irq(err_irq)
    );

    ecc_secded_dec_stream #(.DATA_WIDTH(DWN), .CNT_WIDTH(CWN)) u_dut_n (
        .clk(clk), .rstn(rstn), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_data(n_in_data), .in_ecc(n_in_ecc), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_data(n_out_data), .out_err_sts(n_out_err_sts), .out_syndrome(n_out_syndrome),
        .cnt_clr(n_cnt_clr), .cnt_corr(n_cnt_corr), .cnt_uncorr(n_cnt_uncorr), .err_irq(n_err_irq)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (codeword-array view) ----------------
    function automatic int p_of(input int dw);
        int p = 0;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    function automatic logic [7:0] m_enc(input int dw, input logic [63:0] d);
        int p = p_of(dw);
        int idx = 0;
        int h = 0;
        logic [7:0] e = '0;
        for (int pos = 1; pos <= dw + p; pos++) begin
            if ((pos & (pos - 1)) == 0) continue;
            if (d[idx]) h ^= pos;
            idx++;
        end
        for (int b = 0; b < p; b++) e[b] = h[b];
        e[p] = (^d) ^ (^e);
        return e;
    endfunction

    task automatic m_dec(input int dw, input logic [63:0] d, input logic [7:0] e,
                         output logic [63:0] od, output logic [1:0] sts, output logic [6:0] syn);
        int p = p_of(dw);
        int n = dw + p;
        bit cw[128];
        int idx = 0, hb = 0, s = 0;
        bit m;
        for (int pos = 1; pos <= n; pos++) begin
            if ((pos & (pos - 1)) == 0) begin cw[pos] = e[hb]; hb++; end
            else begin cw[pos] = d[idx]; idx++; end
        end
        m = e[p];
        for (int pos = 1; pos <= n; pos++) if (cw[pos]) begin s ^= pos; m = !m; end
        if (s == 0 && !m)                sts = 2'b00;
        else if (m && s == 0)            sts = 2'b10;
        else if (m && (s & (s - 1)) == 0) sts = 2'b10;
        else if (m && s <= n)            begin sts = 2'b01; cw[s] = !cw[s]; end
        else                             sts = 2'b11;
        od = '0;
        idx = 0;
        for (int pos = 1; pos <= n; pos++) begin
            if ((pos & (pos - 1)) == 0) continue;
            od[idx] = cw[pos];
            idx++;
        end
        syn = 7'(s);
    endtask

    typedef struct { logic [63:0] d; logic [7:0] e; } word_t;
    typedef struct { logic [63:0] d; logic [1:0] sts; logic [6:0] syn; int cyc; } exp_t;

    word_t stim_q[$];
    exp_t  exp_q[$];
    logic [63:0] got_data[$];
    logic [1:0]  got_sts[$];
    logic [6:0]  got_syn[$];
    int m_corr = 0, m_uncorr = 0, m_ncorr = 0;

    function automatic word_t mk_word(input int dw, input int nerr);
        word_t w;
        int tot = dw + p_of(dw) + 1;
        int r1, r2;
        w.d = {$urandom, $urandom};
        if (dw == 32) w.d[63:32] = '0;
        w.e = m_enc(dw, w.d);
        if (nerr >= 3) begin
            w.e = 8'($urandom);
            if (dw == 32) w.e[7] = 1'b0;
        end else begin
            r1 = $urandom_range(0, tot - 1);
            r2 = (r1 + $urandom_range(1, tot - 1)) % tot;
            if (nerr >= 1) begin if (r1 < dw) w.d[r1] = !w.d[r1]; else w.e[r1 - dw] = !w.e[r1 - dw]; end
            if (nerr >= 2) begin if (r2 < dw) w.d[r2] = !w.d[r2]; else w.e[r2 - dw] = !w.e[r2 - dw]; end
        end
        return w;
    endfunction

    // Drives stim_q into the 64-bit DUT and scoreboards everything that comes out.
    task automatic run_stream(input bit rand_ready);
        int cyc = 0, idle = 0;
        bit pending = 0, exp_irq = 0, prev_stall = 0;
        logic [63:0] prev_data;
        logic [1:0]  prev_sts;
        logic [6:0]  prev_syn;
        word_t w;
        exp_t x;
        while (idle < 4 && cyc < LIMIT) begin
            @(posedge clk); #1;
            if (!pending && stim_q.size() > 0 && (!rand_ready || $urandom_range(0, 3) != 0)) begin
                w = stim_q.pop_front();
                in_data = w.d; in_ecc = w.e; in_valid = 1'b1; pending = 1;
            end else if (!pending) begin
                in_valid = 1'b0;
            end
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            cyc++;
            check("err_irq", 64'(err_irq), 64'(exp_irq));
            check("cnt_corr", 64'(cnt_corr), 64'(m_corr));
            check("cnt_uncorr", 64'(cnt_uncorr), 64'(m_uncorr));
            if (exp_q.size() == 0) check("empty_pipe_valid", 64'(out_valid), 64'd0);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, prev_data);
                check("stall_sts", 64'(out_err_sts), 64'(prev_sts));
                check("stall_syn", 64'(out_syndrome), 64'(prev_syn));
            end
            exp_irq = 0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("out_data", out_data, x.d);
                check("out_sts", 64'(out_err_sts), 64'(x.sts));
                check("out_syn", 64'(out_syndrome), 64'(x.syn));
                if (!rand_ready) check("latency", 64'(cyc - x.cyc), 64'd2);
                got_data.push_back(out_data);
                got_sts.push_back(out_err_sts);
                got_syn.push_back(out_syndrome);
                if ((x.sts == 2'b01 || x.sts == 2'b10) && m_corr < (1 << CW) - 1) m_corr++;
                if (x.sts == 2'b11 && m_uncorr < (1 << CW) - 1) m_uncorr++;
                exp_irq = (x.sts == 2'b11);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data; prev_sts = out_err_sts; prev_syn = out_syndrome;
            if (in_valid && in_ready) begin
                m_dec(DW, in_data, in_ecc, x.d, x.sts, x.syn);
                x.cyc = cyc;
                exp_q.push_back(x);
                pending = 0;
            end
            idle = (stim_q.size() == 0 && !pending && exp_q.size() == 0) ? idle + 1 : 0;
        end
        if (cyc >= LIMIT) check("stream_budget", 64'(cyc), 64'(LIMIT - 1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    // One word through the narrow DUT, optionally clearing counters on its handshake.
    task automatic send_n(input logic [31:0] d, input logic [6:0] e, input bit clr);
        logic [63:0] od;
        logic [1:0]  sts;
        logic [6:0]  syn;
        int t = 0;
        m_dec(DWN, {32'h0, d}, {1'b0, e}, od, sts, syn);
        @(posedge clk); #1;
        n_in_valid = 1'b1; n_in_data = d; n_in_ecc = e;
        @(negedge clk);
        check("n_in_ready", 64'(n_in_ready), 64'd1);
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        do begin @(negedge clk); t++; end while (!n_out_valid && t < 10);
        check("n_latency", 64'(t), 64'd2);
        check("n_out_data", 64'(n_out_data), od);
        check("n_out_sts", 64'(n_out_err_sts), 64'(sts));
        check("n_out_syn", 64'(n_out_syndrome), 64'(syn));
        got_syn.push_back(n_out_syndrome);
        got_data.push_back(64'(n_out_data));
        n_cnt_clr = clr;
        if (clr) m_ncorr = 0;
        else if ((sts == 2'b01 || sts == 2'b10) && m_ncorr < 3) m_ncorr++;
        @(posedge clk); #1;
        n_cnt_clr = 1'b0;
        @(negedge clk);
        check("n_cnt_corr", 64'(n_cnt_corr), 64'(m_ncorr));
        check("n_cnt_uncorr", 64'(n_cnt_uncorr), 64'd0);
        check("n_err_irq", 64'(n_err_irq), 64'd0);
    endtask

    localparam logic [63:0] DBEEF = 64'hDEADBEEF_01234567;

    initial begin
        word_t w;
        logic [7:0] e0;
        logic [31:0] dn;
        logic [6:0] en;
        int base;

        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_ecc = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        n_in_valid = 1'b0; n_in_data = '0; n_in_ecc = '0; n_out_ready = 1'b1; n_cnt_clr = 1'b0;
        #17;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_sts", 64'(out_err_sts), 64'd0);
        check("rst_out_syn", 64'(out_syndrome), 64'd0);
        check("rst_cnt_corr", 64'(cnt_corr), 64'd0);
        check("rst_cnt_uncorr", 64'(cnt_uncorr), 64'd0);
        check("rst_err_irq", 64'(err_irq), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed test-plan words, back to back with out_ready high.
        e0 = m_enc(DW, DBEEF);
        w.d = '0;          w.e = '0;              stim_q.push_back(w);
        w.d = DBEEF ^ 64'h1; w.e = e0;            stim_q.push_back(w);
        w.d = DBEEF;       w.e = e0 ^ 8'h80;      stim_q.push_back(w);
        w.d = DBEEF;       w.e = e0 ^ 8'h04;      stim_q.push_back(w);
        w.d = DBEEF ^ 64'h3; w.e = e0;            stim_q.push_back(w);
        run_stream(1'b0);
        check("dir_words", 64'(got_sts.size()), 64'd5);
        if (got_sts.size() == 5) begin
            check("clean_sts", 64'(got_sts[0]), 64'd0);
            check("clean_syn", 64'(got_syn[0]), 64'd0);
            check("clean_data", got_data[0], 64'd0);
            check("sbe_sts", 64'(got_sts[1]), 64'd1);
            check("sbe_syn", 64'(got_syn[1]), 64'd3);
            check("sbe_data", got_data[1], DBEEF);
            check("par_sts", 64'(got_sts[2]), 64'd2);
            check("par_syn", 64'(got_syn[2]), 64'd0);
            check("par_data", got_data[2], DBEEF);
            check("ham_sts", 64'(got_sts[3]), 64'd2);
            check("ham_syn", 64'(got_syn[3]), 64'd4);
            check("ham_data", got_data[3], DBEEF);
            check("dbe_sts", 64'(got_sts[4]), 64'd3);
            check("dbe_syn", 64'(got_syn[4]), 64'd6);
            check("dbe_data", got_data[4], DBEEF ^ 64'h3);
        end
        check("dir_cnt_corr", 64'(cnt_corr), 64'd3);
        check("dir_cnt_uncorr", 64'(cnt_uncorr), 64'd1);

        // Random words with 0/1/2 flips or garbage check bits, random backpressure.
        for (int i = 0; i < 8; i++) stim_q.push_back(mk_word(DW, i % 4));
        run_stream(1'b1);
        for (int i = 0; i < 200; i++) stim_q.push_back(mk_word(DW, $urandom_range(0, 3)));
        run_stream(1'b1);

        // Synchronous counter clear.
        @(posedge clk); #1; cnt_clr = 1'b1;
        @(posedge clk); #1; cnt_clr = 1'b0;
        m_corr = 0; m_uncorr = 0;
        @(negedge clk);
        check("clr_cnt_corr", 64'(cnt_corr), 64'd0);
        check("clr_cnt_uncorr", 64'(cnt_uncorr), 64'd0);

        // Asynchronous reset with words in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = mk_word(DW, 1);
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = w.d; in_ecc = w.e;
        end
        @(posedge clk); #3;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_cnt_corr", 64'(cnt_corr), 64'd0);
        check("mid_rst_cnt_uncorr", 64'(cnt_uncorr), 64'd0);
        check("mid_rst_irq", 64'(err_irq), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);

        // Narrow instance: 32-bit data, 2-bit saturating counter.
        base = got_syn.size();
        dn = 32'h0123_4567;
        en = 7'(m_enc(DWN, {32'h0, dn}));
        send_n(dn ^ 32'h1, en, 1'b0);
        check("n_sbe_syn", 64'(got_syn[base]), 64'd3);
        check("n_sbe_data", got_data[base], 64'h0123_4567);
        for (int i = 0; i < 5; i++) begin
            dn = $urandom;
            en = 7'(m_enc(DWN, {32'h0, dn}));
            send_n(dn ^ (32'h1 << $urandom_range(0, 31)), en, i == 4);
            if (i == 3) check("n_cnt_saturated", 64'(n_cnt_corr), 64'd3);
        end
        check("n_cnt_cleared", 64'(n_cnt_corr), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
